// File: rtl/de_regfile_scoreboard.sv
// DE-stage register file with a counting scoreboard.
// Each register keeps a small count of outstanding writes, so several writes
// to the same register can be in flight (WAW). The block produces the
// RAW/structural stall for FE and an issue strobe. Writebacks and kills
// release the count. Writebacks can optionally bypass to the operand reads
// in the same cycle.
module de_regfile_scoreboard #(
  parameter  int DBITS   = 32,
  parameter  int NREGS   = 32,
  parameter  int NUM_WB  = 1,
  parameter  int CNT_W   = 2,
  parameter  int BYPASS  = 1,
  localparam int REGNO_W = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_in_valid,
  input  logic [REGNO_W-1:0]        i_rs1,
  input  logic [REGNO_W-1:0]        i_rs2,
  input  logic                      i_use_rs1,
  input  logic                      i_use_rs2,
  input  logic [REGNO_W-1:0]        i_rd,
  input  logic                      i_wr_rd,
  input  logic                      i_out_ready,
  input  logic                      i_flush,
  input  logic [NUM_WB-1:0]         i_wb_en,
  input  logic [NUM_WB*REGNO_W-1:0] i_wb_regno,
  input  logic [NUM_WB*DBITS-1:0]   i_wb_data,
  input  logic                      i_kill_en,
  input  logic [REGNO_W-1:0]        i_kill_regno,
  output logic [DBITS-1:0]          o_rs1_val,
  output logic [DBITS-1:0]          o_rs2_val,
  output logic                      o_stall,
  output logic                      o_issue,
  output logic [NREGS-1:0]          o_busy_vec,
  output logic                      o_sb_err
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;
  // Wide enough for cnt + 1 and for up to four writeback ports plus one kill.
  localparam int SUM_W   = CNT_W + 4;

  logic [DBITS-1:0]   r_regs [NREGS];
  logic [CNT_W-1:0]   r_cnt  [NREGS];
  logic [NREGS-1:0]   r_busy_vec;
  logic               r_sb_err;

  logic [2:0]         w_dec      [NREGS];
  logic               w_wr_en    [NREGS];
  logic [DBITS-1:0]   w_wr_data  [NREGS];
  logic [CNT_W-1:0]   w_cnt_nxt  [NREGS];
  logic [NREGS-1:0]   w_underflow;
  logic [NREGS-1:0]   w_busy;
  logic [REGNO_W-1:0] w_src      [2];
  logic [DBITS-1:0]   w_src_val  [2];
  logic               w_full;
  logic               w_stall;
  logic               w_issue;

  assign w_src[0] = i_rs1;
  assign w_src[1] = i_rs2;

  // Per-register release count and write data; later ports override earlier ones.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      // NOTE: every always_comb output gets a default before any conditional
      // assignment, otherwise the untaken path would infer a latch.
      w_dec[r]     = '0;
      w_wr_en[r]   = 1'b0;
      w_wr_data[r] = '0;
      if (r != 0) begin
        for (int p = 0; p < NUM_WB; p++) begin
          if (i_wb_en[p] && i_wb_regno[p*REGNO_W +: REGNO_W] == REGNO_W'(r)) begin
            w_dec[r]     = w_dec[r] + 3'd1;
            w_wr_en[r]   = 1'b1;
            w_wr_data[r] = i_wb_data[p*DBITS +: DBITS];
          end
        end
        if (i_kill_en && i_kill_regno == REGNO_W'(r)) w_dec[r] = w_dec[r] + 3'd1;
      end
    end
  end

  // Effective busy: with bypass, this cycle's releases already count.
  always_comb begin
    w_busy = '0;
    for (int r = 1; r < NREGS; r++) begin
      if (BYPASS != 0) w_busy[r] = SUM_W'(r_cnt[r]) > SUM_W'(w_dec[r]);
      else             w_busy[r] = r_cnt[r] != '0;
    end
  end

  // Operand reads, with optional same-cycle writeback forwarding.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_src_val[s] = '0;
      if (w_src[s] != '0) begin
        w_src_val[s] = r_regs[w_src[s]];
        if (BYPASS != 0) begin
          for (int p = 0; p < NUM_WB; p++) begin
            if (i_wb_en[p] && i_wb_regno[p*REGNO_W +: REGNO_W] == w_src[s])
              w_src_val[s] = i_wb_data[p*DBITS +: DBITS];
          end
        end
      end
    end
  end

  assign w_full  = i_wr_rd && (i_rd != '0) && (r_cnt[i_rd] == CNT_W'(CNT_MAX))
                   && (w_dec[i_rd] == '0);
  assign w_stall = i_in_valid && !i_flush &&
                   ((i_use_rs1 && w_busy[i_rs1]) || (i_use_rs2 && w_busy[i_rs2]) || w_full);
  assign w_issue = i_in_valid && !i_flush && !w_stall && i_out_ready;

  // Next counter value; an over-release clamps to zero and flags an error.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      logic [SUM_W-1:0] v_sum;
      v_sum = SUM_W'(r_cnt[r]);
      if (w_issue && i_wr_rd && i_rd == REGNO_W'(r) && r != 0) v_sum = v_sum + SUM_W'(1);
      w_underflow[r] = SUM_W'(w_dec[r]) > v_sum;
      w_cnt_nxt[r]   = w_underflow[r] ? '0 : CNT_W'(v_sum - SUM_W'(w_dec[r]));
    end
  end

  // Register file, counters, busy vector and sticky error state.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register file storage is reset on purpose; all registers
      // must read 0 after reset, so this is not a plain RAM.
      for (int r = 0; r < NREGS; r++) begin
        r_regs[r] <= '0;
        r_cnt[r]  <= '0;
      end
      r_busy_vec <= '0;
      r_sb_err   <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (w_wr_en[r]) r_regs[r] <= w_wr_data[r];
        r_cnt[r]      <= w_cnt_nxt[r];
        r_busy_vec[r] <= w_cnt_nxt[r] != '0;
      end
      r_sb_err <= r_sb_err | (|w_underflow);
    end
  end

  assign o_rs1_val  = w_src_val[0];
  assign o_rs2_val  = w_src_val[1];
  assign o_stall    = w_stall;
  assign o_issue    = w_issue;
  assign o_busy_vec = r_busy_vec;
  assign o_sb_err   = r_sb_err;

endmodule

// File: tb/tb_de_regfile_scoreboard.sv
// Bench for de_regfile_scoreboard: a bypassing instance (NUM_WB=2) and a
// non-bypassing twin share the same stimulus. Expected values are queued
// when stimulus is applied and popped when the outputs are sampled.
module tb_de_regfile_scoreboard;

  localparam int DBITS = 32;
  localparam int NREGS = 32;
  localparam int RW    = 5;
  localparam int NWB   = 2;

  typedef struct {
    string       name;
    logic [63:0] val;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, use_rs1, use_rs2, wr_rd, out_ready, flush, kill_en;
  logic [RW-1:0]    rs1, rs2, rd, kill_regno;
  logic [NWB-1:0]   wb_en;
  logic [NWB*RW-1:0]    wb_regno;
  logic [NWB*DBITS-1:0] wb_data;

  logic [DBITS-1:0] rs1_val, rs2_val, nb_rs1_val, nb_rs2_val;
  logic             stall, issue, sb_err, nb_stall, nb_issue, nb_sb_err;
  logic [NREGS-1:0] busy_vec, nb_busy_vec;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  de_regfile_scoreboard #(.DBITS(DBITS), .NREGS(NREGS), .NUM_WB(NWB), .CNT_W(2), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .i_in_valid(in_valid), .i_rs1(rs1), .i_rs2(rs2),
    .i_use_rs1(use_rs1), .i_use_rs2(use_rs2), .i_rd(rd), .i_wr_rd(wr_rd),
    .i_out_ready(out_ready), .i_flush(flush), .i_wb_en(wb_en), .i_wb_regno(wb_regno),
    .i_wb_data(wb_data), .i_kill_en(kill_en), .i_kill_regno(kill_regno),
    .o_rs1_val(rs1_val), .o_rs2_val(rs2_val), .o_stall(stall), .o_issue(issue),
    .o_busy_vec(busy_vec), .o_sb_err(sb_err));

  de_regfile_scoreboard #(.DBITS(DBITS), .NREGS(NREGS), .NUM_WB(NWB), .CNT_W(2), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .i_in_valid(in_valid), .i_rs1(rs1), .i_rs2(rs2),
    .i_use_rs1(use_rs1), .i_use_rs2(use_rs2), .i_rd(rd), .i_wr_rd(wr_rd),
    .i_out_ready(out_ready), .i_flush(flush), .i_wb_en(wb_en), .i_wb_regno(wb_regno),
    .i_wb_data(wb_data), .i_kill_en(kill_en), .i_kill_regno(kill_regno),
    .o_rs1_val(nb_rs1_val), .o_rs2_val(nb_rs2_val), .o_stall(nb_stall), .o_issue(nb_issue),
    .o_busy_vec(nb_busy_vec), .o_sb_err(nb_sb_err));

  // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; use_rs1 = 0; use_rs2 = 0; wr_rd = 0; out_ready = 1; flush = 0;
    kill_en = 0; rs1 = '0; rs2 = '0; rd = '0; kill_regno = '0;
    wb_en = '0; wb_regno = '0; wb_data = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic set_wb(input int port, input logic [RW-1:0] regno, input logic [DBITS-1:0] data);
    wb_en[port] = 1'b1;
    wb_regno[port*RW +: RW] = regno;
    wb_data[port*DBITS +: DBITS] = data;
  endtask

  task automatic test_reset();
    apply_reset();
    tick();
    in_valid = 1; use_rs1 = 1; rs1 = 5'd5;
    exp_q.push_back('{"reset_busy_vec", 64'd0});
    exp_q.push_back('{"reset_sb_err", 64'd0});
    exp_q.push_back('{"reset_stall", 64'd0});
    #2;
    e = exp_q.pop_front(); n_checks++; if (64'(busy_vec) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, busy_vec, e.val); end
    e = exp_q.pop_front(); n_checks++; if (64'(sb_err) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, sb_err, e.val); end
    e = exp_q.pop_front(); n_checks++; if (64'(stall) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, stall, e.val); end
    in_valid = 0; use_rs1 = 0;
    for (int r = 0; r < NREGS; r++) begin
      rs1 = RW'(r); rs2 = RW'(NREGS - 1 - r);
      exp_q.push_back('{$sformatf("reset_read_r%0d", r), 64'd0});
      #1;
      e = exp_q.pop_front(); n_checks++; if (64'({rs1_val, rs2_val}) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, {rs1_val, rs2_val}, e.val); end
    end
  endtask

  task automatic test_raw_bypass();
    apply_reset();
    in_valid = 1; wr_rd = 1; rd = 5'd5;
    exp_q.push_back('{"raw_issue_rd5", 64'd1});
    #2;
    e = exp_q.pop_front(); n_checks++; if (64'(issue) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, issue, e.val); end
    tick();
    wr_rd = 0; use_rs1 = 1; rs1 = 5'd5;
    exp_q.push_back('{"raw_stall_byp", 64'd1});
    exp_q.push_back('{"raw_stall_nobyp", 64'd1});
    #2;
    e = exp_q.pop_front(); n_checks++; if (64'(stall) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, stall, e.val); end
    e = exp_q.pop_front(); n_checks++; if (64'(nb_stall) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, nb_stall, e.val); end
    set_wb(0, 5'd5, 32'hDEADBEEF);
    exp_q.push_back('{"raw_wb_stall_byp", 64'd0});
    exp_q.push_back('{"raw_wb_val_byp", 64'hDEADBEEF});
    exp_q.push_back('{"raw_wb_stall_nobyp", 64'd1});
    exp_q.push_back('{"raw_wb_val_nobyp", 64'd0});
    #1;
    e = exp_q.pop_front(); n_checks++; if (64'(stall) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, stall, e.val); end
    e = exp_q.pop_front(); n_checks++; if (64'(rs1_val) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rs1_val, e.val); end
    e = exp_q.pop_front(); n_checks++; if (64'(nb_stall) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, nb_stall, e.val); end
    e = exp_q.pop_front(); n_checks++; if (64'(nb_rs1_val) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, nb_rs1_val, e.val); end
    tick();
    wb_en = '0;
    exp_q.push_back('{"raw_after_stall_nobyp", 64'd0});
    exp_q.push_back('{"raw_after_val_nobyp", 64'hDEADBEEF});
    exp_q.push_back('{"raw_after_busy5", 64'd0});
    #2;
    e = exp_q.pop_front(); n_checks++; if (64'(nb_stall) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, nb_stall, e.val); end
    e = exp_q.pop_front(); n_checks++; if (64'(nb_rs1_val) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, nb_rs1_val, e.val); end
    e = exp_q.pop_front(); n_checks++; if (64'(busy_vec[5]) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, busy_vec[5], e.val); end
  endtask

  task automatic test_waw_limit();
    apply_reset();
    in_valid = 1; wr_rd = 1; rd = 5'd7;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{$sformatf("waw_issue_%0d", k), 64'd1});
      #2;
      e = exp_q.pop_front(); n_checks++; if (64'(issue) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, issue, e.val); end
      tick();
    end
    exp_q.push_back('{"waw_full_stall", 64'd1});
    exp_q.push_back('{"waw_full_issue", 64'd0});
    exp_q.push_back('{"waw_busy7", 64'd1});
    #2;
    e = exp_q.pop_front(); n_checks++; if (64'(stall) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, stall, e.val); end
    e = exp_q.pop_front(); n_checks++; if (64'(issue) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, issue, e.val); end
    e = exp_q.pop_front(); n_checks++; if (64'(busy_vec[7]) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, busy_vec[7], e.val); end
    set_wb(0, 5'd7, 32'h70);
    exp_q.push_back('{"waw_release_stall", 64'd0});
    exp_q.push_back('{"waw_release_issue", 64'd1});
    #1;
    e = exp_q.pop_front(); n_checks++; if (64'(stall) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, stall, e.val); end
    e = exp_q.pop_front(); n_checks++; if (64'(issue) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, issue, e.val); end
    tick();
    in_valid = 0; wr_rd = 0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{$sformatf("waw_drain_busy7_%0d", k), (k < 2) ? 64'd1 : 64'd0});
      tick();
      #2;
      e = exp_q.pop_front(); n_checks++; if (64'(busy_vec[7]) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, busy_vec[7], e.val); end
    end
    wb_en = '0;
    exp_q.push_back('{"waw_no_err", 64'd0});
    tick();
    #2;
    e = exp_q.pop_front(); n_checks++; if (64'(sb_err) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, sb_err, e.val); end
  endtask

  task automatic test_dual_wb();
    apply_reset();
    in_valid = 1; wr_rd = 1; rd = 5'd9;
    tick();
    tick();
    idle_inputs();
    set_wb(0, 5'd9, 32'h11);
    set_wb(1, 5'd9, 32'h22);
    rs1 = 5'd9;
    exp_q.push_back('{"dual_bypass_val", 64'h22});
    #2;
    e = exp_q.pop_front(); n_checks++; if (64'(rs1_val) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rs1_val, e.val); end
    tick();
    wb_en = '0;
    exp_q.push_back('{"dual_stored_val", 64'h22});
    exp_q.push_back('{"dual_busy9", 64'd0});
    exp_q.push_back('{"dual_no_err", 64'd0});
    #2;
    e = exp_q.pop_front(); n_checks++; if (64'(rs1_val) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rs1_val, e.val); end
    e = exp_q.pop_front(); n_checks++; if (64'(busy_vec[9]) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, busy_vec[9], e.val); end
    e = exp_q.pop_front(); n_checks++; if (64'(sb_err) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, sb_err, e.val); end
  endtask

  task automatic test_kill();
    apply_reset();
    in_valid = 1; wr_rd = 1; rd = 5'd3;
    tick();
    idle_inputs();
    set_wb(0, 5'd3, 32'h33);
    tick();
    wb_en = '0;
    in_valid = 1; wr_rd = 1; rd = 5'd3;
    tick();
    idle_inputs();
    kill_en = 1; kill_regno = 5'd3;
    tick();
    kill_en = 0; rs2 = 5'd3;
    exp_q.push_back('{"kill_busy3", 64'd0});
    exp_q.push_back('{"kill_no_err", 64'd0});
    exp_q.push_back('{"kill_reg3_kept", 64'h33});
    #2;
    e = exp_q.pop_front(); n_checks++; if (64'(busy_vec[3]) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, busy_vec[3], e.val); end
    e = exp_q.pop_front(); n_checks++; if (64'(sb_err) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, sb_err, e.val); end
    e = exp_q.pop_front(); n_checks++; if (64'(rs2_val) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rs2_val, e.val); end
    kill_en = 1;
    tick();
    kill_en = 0;
    exp_q.push_back('{"kill_extra_err", 64'd1});
    exp_q.push_back('{"kill_extra_busy3", 64'd0});
    #2;
    e = exp_q.pop_front(); n_checks++; if (64'(sb_err) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, sb_err, e.val); end
    e = exp_q.pop_front(); n_checks++; if (64'(busy_vec[3]) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, busy_vec[3], e.val); end
    for (int k = 0; k < 3; k++) tick();
    exp_q.push_back('{"kill_err_sticky", 64'd1});
    #2;
    e = exp_q.pop_front(); n_checks++; if (64'(sb_err) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, sb_err, e.val); end
    apply_reset();
    exp_q.push_back('{"kill_err_cleared", 64'd0});
    #2;
    e = exp_q.pop_front(); n_checks++; if (64'(sb_err) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, sb_err, e.val); end
  endtask

  task automatic test_hold_and_reset();
    apply_reset();
    in_valid = 1; wr_rd = 1; rd = 5'd4; flush = 1;
    exp_q.push_back('{"flush_issue", 64'd0});
    #2;
    e = exp_q.pop_front(); n_checks++; if (64'(issue) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, issue, e.val); end
    tick();
    flush = 0; out_ready = 0;
    exp_q.push_back('{"flush_busy_vec", 64'd0});
    exp_q.push_back('{"not_ready_issue", 64'd0});
    #2;
    e = exp_q.pop_front(); n_checks++; if (64'(busy_vec) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, busy_vec, e.val); end
    e = exp_q.pop_front(); n_checks++; if (64'(issue) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, issue, e.val); end
    tick();
    out_ready = 1;
    exp_q.push_back('{"not_ready_busy_vec", 64'd0});
    #2;
    e = exp_q.pop_front(); n_checks++; if (64'(busy_vec) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, busy_vec, e.val); end
    tick();
    tick();
    idle_inputs();
    exp_q.push_back('{"two_issued_busy4", 64'd1});
    #2;
    e = exp_q.pop_front(); n_checks++; if (64'(busy_vec[4]) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, busy_vec[4], e.val); end
    reset = 1;
    set_wb(0, 5'd4, 32'h44);
    kill_en = 1; kill_regno = 5'd4;
    tick();
    reset = 0;
    idle_inputs();
    in_valid = 1; use_rs1 = 1; rs1 = 5'd4;
    exp_q.push_back('{"midreset_busy_vec", 64'd0});
    exp_q.push_back('{"midreset_stall", 64'd0});
    exp_q.push_back('{"midreset_reg4", 64'd0});
    exp_q.push_back('{"midreset_err", 64'd0});
    #2;
    e = exp_q.pop_front(); n_checks++; if (64'(busy_vec) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, busy_vec, e.val); end
    e = exp_q.pop_front(); n_checks++; if (64'(stall) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, stall, e.val); end
    e = exp_q.pop_front(); n_checks++; if (64'(rs1_val) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rs1_val, e.val); end
    e = exp_q.pop_front(); n_checks++; if (64'(sb_err) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, sb_err, e.val); end
    // A single release now must underflow, proving the count really went to 0.
    idle_inputs();
    set_wb(0, 5'd4, 32'h45);
    tick();
    wb_en = '0;
    exp_q.push_back('{"midreset_cnt_zero", 64'd1});
    #2;
    e = exp_q.pop_front(); n_checks++; if (64'(sb_err) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, sb_err, e.val); end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    tick();
    test_reset();
    test_raw_bypass();
    test_waw_limit();
    test_dual_wb();
    test_kill();
    test_hold_and_reset();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expectations: got %0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
